// File: rtl/mux3_rr_arbiter_if.sv
// Requester/resource-side signal bundle for mux3_rr_arbiter.
// The master modport is the arbiter; slave is the requesters plus the shared resource.
interface mux3_rr_arbiter_if;
  logic [2:0] req;
  logic [1:0] sel;
  logic [2:0] grant;
  logic       bus_valid;
  logic       bus_ready;
  logic       bus_done;
  logic [2:0] ack;
  logic       err;
  logic       busy;

  modport master (
    input  req, bus_ready, bus_done,
    output sel, grant, bus_valid, ack, err, busy
  );

  modport slave (
    output req, bus_ready, bus_done,
    input  sel, grant, bus_valid, ack, err, busy
  );
endinterface

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter/sequencer for a 3-input shared resource with valid/ready/done handshake.
// Optional abort timer enabled by defining ARB3_TIMEOUT_EN.
module mux3_rr_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                resetn,
  mux3_rr_arbiter_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_t;

  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t     r_state;
  logic [1:0] r_sel;
  logic [2:0] r_grant;
  logic       r_valid;
  logic [2:0] r_ack;
  logic       r_err;
  logic       r_busy;
  logic [1:0] r_last;

  logic       w_pick_vld;
  logic [1:0] w_pick_idx;
  logic       w_complete;
  logic       w_tmo;

  // Scan order starts one past the last winner, ending with the last winner itself.
  always_comb begin
    w_pick_vld = |bus.req;
    w_pick_idx = 2'd0;
    case (r_last)
      2'd0: begin
        if (bus.req[1])      w_pick_idx = 2'd1;
        else if (bus.req[2]) w_pick_idx = 2'd2;
        else                 w_pick_idx = 2'd0;
      end
      2'd1: begin
        if (bus.req[2])      w_pick_idx = 2'd2;
        else if (bus.req[0]) w_pick_idx = 2'd0;
        else                 w_pick_idx = 2'd1;
      end
      default: begin
        if (bus.req[0])      w_pick_idx = 2'd0;
        else if (bus.req[1]) w_pick_idx = 2'd1;
        else                 w_pick_idx = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_complete = 1'b0;
    case (r_state)
      S_ISSUE: w_complete = bus.bus_ready && bus.bus_done;
      S_WAIT:  w_complete = bus.bus_done;
      default: w_complete = 1'b0;
    endcase
  end

`ifdef ARB3_TIMEOUT_EN
  logic [7:0] r_cnt;

  // Cleared in IDLE/ACK, so it is already zero on entry to ISSUE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE || r_state == S_WAIT) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_tmo = (r_state == S_ISSUE || r_state == S_WAIT) && (r_cnt == LP_TMO_LAST);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^LP_TMO_LAST;
  assign w_tmo        = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_sel   <= 2'b00;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_last  <= 2'd2;
    end else begin
      r_ack <= '0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_sel   <= w_pick_idx;
            r_grant <= 3'(3'b001 << w_pick_idx);
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_complete || w_tmo) begin
            r_valid <= 1'b0;
            r_ack   <= r_grant;
            r_err   <= w_tmo && !w_complete;
            r_state <= S_ACK;
          end else if (bus.bus_ready) begin
            r_valid <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_complete || w_tmo) begin
            r_ack   <= r_grant;
            r_err   <= w_tmo && !w_complete;
            r_state <= S_ACK;
          end
        end
        default: begin
          r_last  <= r_sel;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sel       = r_sel;
  assign bus.grant     = r_grant;
  assign bus.bus_valid = r_valid;
  assign bus.ack       = r_ack;
  assign bus.err       = r_err;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Scoreboard bench for mux3_rr_arbiter: expected acks queued at stimulus, checked when ack fires.
// Covers timeout behaviour for both ARB3_TIMEOUT_EN builds.
module tb_mux3_rr_arbiter;

  typedef struct {
    logic [2:0] ack;
    logic [1:0] sel;
    logic       err;
  } exp_t;

  logic clk;
  logic resetn;
  mux3_rr_arbiter_if bus ();

  mux3_rr_arbiter #(.TIMEOUT_CYC(8)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_acks   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] a, input logic [1:0] s, input logic e);
    exp_t x;
    x.ack = a;
    x.sel = s;
    x.err = e;
    q_exp.push_back(x);
  endtask

  task automatic wait_acks(input string tag, input int n, input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      tick();
      if (bus.ack != 3'b000) seen++;
    end
    check_eq(tag, 32'(seen), 32'(n));
  endtask

  // Scoreboard consumer: every ack must match the head of the expected queue.
  always @(negedge clk) begin
    if (resetn && bus.ack != 3'b000) begin
      n_acks++;
      if (q_exp.size() == 0) begin
        check_eq("unexpected_ack", 32'(bus.ack), 32'(0));
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        check_eq("sb_ack",   32'(bus.ack),       32'(e.ack));
        check_eq("sb_sel",   32'(bus.sel),       32'(e.sel));
        check_eq("sb_grant", 32'(bus.grant),     32'(e.ack));
        check_eq("sb_err",   32'(bus.err),       32'(e.err));
        check_eq("sb_valid", 32'(bus.bus_valid), 32'(0));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks_before;
    int n;

    resetn        = 1'b0;
    bus.req       = 3'b000;
    bus.bus_ready = 1'b0;
    bus.bus_done  = 1'b0;

    // Reset state
    tick(); tick();
    check_eq("rst_sel",   32'(bus.sel),       32'(0));
    check_eq("rst_grant", 32'(bus.grant),     32'(0));
    check_eq("rst_valid", 32'(bus.bus_valid), 32'(0));
    check_eq("rst_ack",   32'(bus.ack),       32'(0));
    check_eq("rst_err",   32'(bus.err),       32'(0));
    check_eq("rst_busy",  32'(bus.busy),      32'(0));
    resetn = 1'b1;
    tick(); tick(); tick();
    check_eq("idle_busy",  32'(bus.busy),      32'(0));
    check_eq("idle_valid", 32'(bus.bus_valid), 32'(0));

    // Single request with immediate ready/done
    bus.req = 3'b010; bus.bus_ready = 1'b1; bus.bus_done = 1'b1;
    push_exp(3'b010, 2'b01, 1'b0);
    tick();
    check_eq("single_grant", 32'(bus.grant),     32'(3'b010));
    check_eq("single_sel",   32'(bus.sel),       32'(2'b01));
    check_eq("single_valid", 32'(bus.bus_valid), 32'(1));
    check_eq("single_busy",  32'(bus.busy),      32'(1));
    tick();
    check_eq("single_ack",      32'(bus.ack),       32'(3'b010));
    check_eq("single_valid_ack", 32'(bus.bus_valid), 32'(0));
    bus.req = 3'b000;
    tick();
    check_eq("single_idle_busy",  32'(bus.busy),  32'(0));
    check_eq("single_idle_grant", 32'(bus.grant), 32'(0));
    check_eq("single_idle_ack",   32'(bus.ack),   32'(0));
    check_eq("single_idle_sel",   32'(bus.sel),   32'(2'b01));

    // Fairness: all three held, last=1 now so order continues 2,0,1,2
    push_exp(3'b100, 2'b10, 1'b0);
    push_exp(3'b001, 2'b00, 1'b0);
    push_exp(3'b010, 2'b01, 1'b0);
    push_exp(3'b100, 2'b10, 1'b0);
    bus.req = 3'b111;
    wait_acks("fair_acks", 4, 40);
    bus.req = 3'b000;
    tick();

    // Reset to restore last=2, then the plain 0,1,2,0 rotation
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    tick();
    push_exp(3'b001, 2'b00, 1'b0);
    push_exp(3'b010, 2'b01, 1'b0);
    push_exp(3'b100, 2'b10, 1'b0);
    push_exp(3'b001, 2'b00, 1'b0);
    bus.req = 3'b111;
    wait_acks("fair2_acks", 4, 40);
    bus.req = 3'b000;
    tick();
    check_eq("fair2_idle", 32'(bus.busy), 32'(0));

    // Rotation skip: req0 last served, req=101 must pick req2 first
    push_exp(3'b100, 2'b10, 1'b0);
    push_exp(3'b001, 2'b00, 1'b0);
    bus.req = 3'b101;
    tick();
    check_eq("skip_sel",   32'(bus.sel),   32'(2'b10));
    check_eq("skip_grant", 32'(bus.grant), 32'(3'b100));
    wait_acks("skip_ack1", 1, 10);
    bus.req = 3'b001;
    wait_acks("skip_ack2", 1, 10);
    bus.req = 3'b000;
    tick();

    // Stalls: ready after 4 ISSUE cycles, done on 5th WAIT cycle; req drop ignored
    acks_before = n_acks;
    bus.bus_ready = 1'b0; bus.bus_done = 1'b0;
    push_exp(3'b001, 2'b00, 1'b0);
    bus.req = 3'b001;
    tick();
    for (int c = 1; c <= 4; c++) begin
      check_eq("stall_issue_valid", 32'(bus.bus_valid), 32'(1));
      check_eq("stall_issue_sel",   32'(bus.sel),       32'(2'b00));
      check_eq("stall_issue_grant", 32'(bus.grant),     32'(3'b001));
      if (c == 1) bus.req = 3'b000;
      bus.bus_done  = (c == 2);
      bus.bus_ready = (c == 4);
      tick();
    end
    bus.bus_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check_eq("stall_wait_valid", 32'(bus.bus_valid), 32'(0));
      check_eq("stall_wait_grant", 32'(bus.grant),     32'(3'b001));
      check_eq("stall_wait_ack",   32'(bus.ack),       32'(0));
      bus.bus_done = (c == 5);
      tick();
    end
    check_eq("stall_ack", 32'(bus.ack), 32'(3'b001));
    bus.bus_done = 1'b0;
    tick(); tick(); tick();
    check_eq("stall_one_ack", 32'(n_acks - acks_before), 32'(1));

    // Mid-transaction reset: outputs drop at once, no ack, last back to 2
    acks_before = n_acks;
    bus.req = 3'b010;
    tick();
    check_eq("mrst_valid_pre", 32'(bus.bus_valid), 32'(1));
    resetn = 1'b0;
    #1;
    check_eq("mrst_valid", 32'(bus.bus_valid), 32'(0));
    check_eq("mrst_grant", 32'(bus.grant),     32'(0));
    check_eq("mrst_busy",  32'(bus.busy),      32'(0));
    bus.req = 3'b000;
    tick(); tick();
    resetn = 1'b1;
    bus.req = 3'b111; bus.bus_ready = 1'b1; bus.bus_done = 1'b1;
    push_exp(3'b001, 2'b00, 1'b0);
    tick();
    check_eq("mrst_sel",   32'(bus.sel),   32'(2'b00));
    check_eq("mrst_grant2", 32'(bus.grant), 32'(3'b001));
    wait_acks("mrst_ack", 1, 10);
    bus.req = 3'b000;
    tick(); tick();
    check_eq("mrst_acks", 32'(n_acks - acks_before), 32'(1));

`ifdef ARB3_TIMEOUT_EN
    // Timeout after 8 cycles in ISSUE/WAIT
    bus.bus_ready = 1'b1; bus.bus_done = 1'b0;
    push_exp(3'b001, 2'b00, 1'b1);
    bus.req = 3'b001;
    tick();
    bus.req = 3'b000;
    n = 0;
    while (bus.ack == 3'b000 && n < 50) begin
      n++;
      tick();
    end
    check_eq("tmo_cycles", 32'(n),          32'(8));
    check_eq("tmo_err",    32'(bus.err),    32'(1));
    tick();
    check_eq("tmo_err_clr", 32'(bus.err), 32'(0));

    // Completion on the limit cycle is a normal completion
    push_exp(3'b001, 2'b00, 1'b0);
    bus.req = 3'b001;
    tick();
    bus.req = 3'b000;
    for (int c = 1; c <= 8; c++) begin
      bus.bus_done = (c == 8);
      tick();
    end
    check_eq("tmo_edge_ack", 32'(bus.ack), 32'(3'b001));
    check_eq("tmo_edge_err", 32'(bus.err), 32'(0));
    bus.bus_done = 1'b0; bus.bus_ready = 1'b0;
    tick();
`else
    // No timer: stays in WAIT indefinitely
    bus.bus_ready = 1'b1; bus.bus_done = 1'b0;
    push_exp(3'b001, 2'b00, 1'b0);
    acks_before = n_acks;
    bus.req = 3'b001;
    tick();
    bus.req = 3'b000;
    for (int c = 0; c < 40; c++) tick();
    check_eq("hang_acks",  32'(n_acks - acks_before), 32'(0));
    check_eq("hang_err",   32'(bus.err),       32'(0));
    check_eq("hang_busy",  32'(bus.busy),      32'(1));
    check_eq("hang_valid", 32'(bus.bus_valid), 32'(0));
    bus.bus_done = 1'b1;
    wait_acks("hang_release", 1, 5);
    bus.bus_done = 1'b0; bus.bus_ready = 1'b0;
    tick();
`endif

    tick(); tick();
    check_eq("sb_empty", 32'(q_exp.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux3_rr_arbiter.md
Name: mux3_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a 3-input shared datapath resource, e.g. a single memory/bus port fed through the 3-way 32-bit select mux.
- Accepts requests from three requesters and grants one at a time.
- Drives the mux select and a one-hot grant, runs a valid/ready/done handshake with the resource, and returns a one-cycle ack to the winner.
- Sits between the pipeline-side requesters (IF, MEM, debug/DMA) and the shared resource.

Parameters:
- TIMEOUT_CYC, 16, cycles allowed in ISSUE+WAIT before abort (used only when ARB3_TIMEOUT_EN is defined); legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- req  input  3  request per requester, level, held until ack
- sel  output  2  mux select: 2'b00 = req0, 2'b01 = req1, 2'b10 = req2; 2'b11 never driven
- grant  output  3  one-hot owner of current transaction, 0 when none
- bus_valid  output  1  transaction presented to resource
- bus_ready  input  1  resource accepted transaction
- bus_done  input  1  resource completed transaction
- ack  output  3  one-hot, one-cycle completion to owner
- err  output  1  asserted with ack on timeout abort; 0 without macro
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, sel=2'b00, grant=0, bus_valid=0, ack=0, err=0, busy=0, last=2 (so req0 wins first).
- States:
  - IDLE: if req!=0, pick first set index scanning last+1, last+2, last (mod 3); register grant/sel; go to ISSUE. Else stay. sel holds previous value in IDLE; grant=0.
  - ISSUE: bus_valid=1, grant/sel stable.
    - bus_ready=1 and bus_done=0 -> WAIT.
    - bus_ready=1 and bus_done=1 -> ACK.
    - bus_ready=0 -> stay.
  - WAIT: bus_valid=0; bus_done=1 -> ACK.
  - ACK: ack=grant for exactly one cycle; last=granted index; grant cleared on exit; no arbitration this cycle; -> IDLE.
- Requester must deassert req in the cycle after its ack unless it wants another transaction. A req still high in IDLE re-enters arbitration with normal round-robin priority.
- req deassert during ISSUE/WAIT is ignored; transaction completes and ack is still issued.
- bus_done in ISSUE without bus_ready is ignored. bus_done in IDLE/ACK is ignored.
- Latency: req seen in IDLE -> bus_valid next cycle. Minimum 3 cycles per transaction (IDLE, ISSUE, ACK).
- sel changes only on IDLE->ISSUE transition; stable through ISSUE, WAIT, ACK.
- Reset mid-transaction: bus_valid and grant drop immediately, no ack issued, last returns to 2.

Optional Feature:
- Macro ARB3_TIMEOUT_EN.
- Defined: 8-bit counter cleared on entry to ISSUE, incremented each cycle in ISSUE/WAIT. When it reaches TIMEOUT_CYC with no completion, go to ACK with err=1 alongside ack (one cycle), bus_valid dropped. Completion on the same cycle as the limit counts as normal completion (err=0).
- Not defined: no counter, err tied 0, arbiter waits indefinitely in ISSUE/WAIT.

Test Plan:
- Reset check: hold resetn=0 -> sel=00, grant=000, bus_valid=0, ack=000, err=0, busy=0. Release with req=000 -> stays IDLE.
- Single request: req=010, bus_ready=bus_done=1 -> cycle1 grant=010, sel=01, bus_valid=1; cycle2 ack=010, bus_valid=0; cycle3 IDLE.
- Fairness: req=111 held continuously, immediate ready/done -> ack order 001, 010, 100, 001, with sel 00, 01, 10, 00.
- Rotation skip: after req0 served, req=101 -> req2 granted (sel=10) before req0.
- Stalls: bus_ready after 3 cycles, bus_done 5 cycles later -> bus_valid high 4 cycles, sel/grant stable throughout, exactly one ack. Mid-transaction resetn=0 -> bus_valid=0 immediately, no ack.
- Timeout (ARB3_TIMEOUT_EN, TIMEOUT_CYC=8): req=001, bus_ready=1, bus_done never -> ack=001 and err=1 for one cycle after 8 cycles. Without macro -> stays in WAIT, err=0.
